fullmatch_mem_2page: RTL and testbench

//  Two-page full-match buffer sitting directly downstream of the MatchCalculator fullmatch

---
 rtl/fm_mem_pkg.sv | 18 +
 rtl/fm_page_ctrl.sv | 58 +++++
 rtl/fullmatch_mem_2page.sv | 81 ++++++++
 tb/tb_fullmatch_mem_2page.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fm_mem_pkg.sv
// Shared definitions for the two-page full-match buffer: word/count widths,
// the per-page fill state and the stored full-match word type.
package fm_mem_pkg;

    localparam int DATA_W  = 45;
    localparam int ENTRY_W = 7;
    localparam int NENT_W  = 8;
    localparam int ADDR_W  = ENTRY_W + 1;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        VALID   = 2'd2
    } page_state_t;

    typedef logic [DATA_W-1:0] fm_word_t;

endpackage

// File: rtl/fm_page_ctrl.sv
// Fill-state tracker for one BX page: counts writes landing in the page,
// latches the producer's final entry count and flags any disagreement
// between that count and the writes actually seen.
module fm_page_ctrl
    import fm_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              nent_we,
    input  logic [NENT_W-1:0] nent_din,
    output logic [NENT_W-1:0] nent_dout,
    output logic              valid,
    output logic              count_err
);

    localparam logic [NENT_W-1:0] WCNT_MAX = NENT_W'(1 << ENTRY_W);

    page_state_t       state;
    logic [NENT_W-1:0] wcnt;
    logic [NENT_W-1:0] wcnt_base;
    logic [NENT_W-1:0] wcnt_eff;

    // Write count for the current BX, including a write arriving this cycle;
    // a page that is not FILLING starts a fresh BX from zero.
    always_comb begin
        wcnt_base = (state == FILLING) ? wcnt : '0;
        wcnt_eff  = wcnt_base;
        if (wr) begin
            wcnt_eff = (wcnt_base == WCNT_MAX) ? WCNT_MAX : wcnt_base + NENT_W'(1);
        end
    end

    // Page FSM: a final count closes the BX (and wins over a same-cycle
    // write, which is still counted); a write reopens the page for filling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            wcnt      <= '0;
            nent_dout <= '0;
            count_err <= 1'b0;
        end else if (nent_we) begin
            state     <= VALID;
            wcnt      <= wcnt_eff;
            nent_dout <= nent_din;
            if (nent_din != wcnt_eff) begin
                count_err <= 1'b1;
            end
        end else if (wr) begin
            state     <= FILLING;
            wcnt      <= wcnt_eff;
            nent_dout <= '0;
        end
    end

    assign valid = (state == VALID);

endmodule

// File: rtl/fullmatch_mem_2page.sv
// Two-page full-match buffer between the match calculator and the track
// builder. Holds the RAM and the 1-cycle read path; each page's fill state
// lives in its own fm_page_ctrl.
// Optional macro FM_MEM_RDW_BYPASS_EN: a read and write to the same address
// in one cycle returns the new data (write-first); otherwise the old word.
module fullmatch_mem_2page
    import fm_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wea,
    input  logic [ADDR_W-1:0] writeaddr,
    input  logic [DATA_W-1:0] din,
    input  logic              nentries_0_we,
    input  logic [NENT_W-1:0] nentries_0_din,
    input  logic              nentries_1_we,
    input  logic [NENT_W-1:0] nentries_1_din,
    input  logic              enb,
    input  logic [ADDR_W-1:0] readaddr,
    output logic [DATA_W-1:0] dout,
    output logic [NENT_W-1:0] nentries_0_dout,
    output logic [NENT_W-1:0] nentries_1_dout,
    output logic [1:0]        page_valid,
    output logic [1:0]        count_err
);

    fm_word_t mem [0:(1 << ADDR_W)-1];

    logic wr_page0;
    logic wr_page1;

    assign wr_page0 = wea && !writeaddr[ADDR_W-1];
    assign wr_page1 = wea &&  writeaddr[ADDR_W-1];

    // Storage array; contents survive reset, only fill bookkeeping is cleared.
    always_ff @(posedge clk) begin
        if (wea) begin
            mem[writeaddr] <= din;
        end
    end

    // Registered read port; dout holds its last value while enb is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
        end else if (enb) begin
`ifdef FM_MEM_RDW_BYPASS_EN
            if (wea && (readaddr == writeaddr)) begin
                dout <= din;
            end else begin
                dout <= mem[readaddr];
            end
`else
            dout <= mem[readaddr];
`endif
        end
    end

    fm_page_ctrl u_page0 (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr_page0),
        .nent_we   (nentries_0_we),
        .nent_din  (nentries_0_din),
        .nent_dout (nentries_0_dout),
        .valid     (page_valid[0]),
        .count_err (count_err[0])
    );

    fm_page_ctrl u_page1 (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr_page1),
        .nent_we   (nentries_1_we),
        .nent_din  (nentries_1_din),
        .nent_dout (nentries_1_dout),
        .valid     (page_valid[1]),
        .count_err (count_err[1])
    );

endmodule

// File: tb/tb_fullmatch_mem_2page.sv
// Directed bench for fullmatch_mem_2page: fill/close both pages, count
// mismatch stickiness, page reuse, read-during-write and async reset.
module tb_fullmatch_mem_2page;

    logic        clk;
    logic        reset;
    logic        wea;
    logic [7:0]  writeaddr;
    logic [44:0] din;
    logic        nentries_0_we;
    logic [7:0]  nentries_0_din;
    logic        nentries_1_we;
    logic [7:0]  nentries_1_din;
    logic        enb;
    logic [7:0]  readaddr;
    logic [44:0] dout;
    logic [7:0]  nentries_0_dout;
    logic [7:0]  nentries_1_dout;
    logic [1:0]  page_valid;
    logic [1:0]  count_err;

    int          num_checks;
    int          num_pass;
    logic [44:0] exp_rdw;

    fullmatch_mem_2page dut (
        .clk             (clk),
        .reset           (reset),
        .wea             (wea),
        .writeaddr       (writeaddr),
        .din             (din),
        .nentries_0_we   (nentries_0_we),
        .nentries_0_din  (nentries_0_din),
        .nentries_1_we   (nentries_1_we),
        .nentries_1_din  (nentries_1_din),
        .enb             (enb),
        .readaddr        (readaddr),
        .dout            (dout),
        .nentries_0_dout (nentries_0_dout),
        .nentries_1_dout (nentries_1_dout),
        .page_valid      (page_valid),
        .count_err       (count_err)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, let one edge pass, then drop the strobes.
    task automatic applyStimulus(input logic w, input logic [7:0] wa, input logic [44:0] d,
                                 input logic r, input logic [7:0] ra,
                                 input logic n0w, input logic [7:0] n0d,
                                 input logic n1w, input logic [7:0] n1d);
        wea            = w;
        writeaddr      = wa;
        din            = d;
        enb            = r;
        readaddr       = ra;
        nentries_0_we  = n0w;
        nentries_0_din = n0d;
        nentries_1_we  = n1w;
        nentries_1_din = n1d;
        tick();
        wea           = 1'b0;
        enb           = 1'b0;
        nentries_0_we = 1'b0;
        nentries_1_we = 1'b0;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        num_checks++;
        assert (observed === expected) num_pass++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // Linear directed sequence.
    initial begin
        num_checks     = 0;
        num_pass       = 0;
        reset          = 1'b1;
        wea            = 1'b0;
        writeaddr      = '0;
        din            = '0;
        enb            = 1'b0;
        readaddr       = '0;
        nentries_0_we  = 1'b0;
        nentries_0_din = '0;
        nentries_1_we  = 1'b0;
        nentries_1_din = '0;

        #12;
        checkOutput("rst_dout", dout, 0);
        checkOutput("rst_page_valid", page_valid, 0);
        checkOutput("rst_count_err", count_err, 0);
        checkOutput("rst_n0", nentries_0_dout, 0);
        checkOutput("rst_n1", nentries_1_dout, 0);
        tick();
        reset = 1'b0;
        tick();

        // 1: three writes to page 0, close with count 3, read back entry 1
        $display("[TB] step 1: page 0 fill");
        applyStimulus(1, 8'h00, 45'h1A5, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 8'h01, 45'h1A6, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 8'h02, 45'h1A7, 0, 0, 0, 0, 0, 0);
        checkOutput("s1_filling_pv", page_valid, 2'b00);
        applyStimulus(0, 0, 0, 0, 0, 1, 8'd3, 0, 0);
        checkOutput("s1_pv", page_valid, 2'b01);
        checkOutput("s1_n0", nentries_0_dout, 3);
        checkOutput("s1_err", count_err, 2'b00);
        enb      = 1'b1;
        readaddr = 8'h01;
        #1;
        checkOutput("s1_rd_before_edge", dout, 0);
        tick();
        enb = 1'b0;
        checkOutput("s1_rd", dout, 45'h1A6);
        tick();
        checkOutput("s1_rd_hold", dout, 45'h1A6);

        // 2: page 1 two writes, count says 5 -> sticky error
        $display("[TB] step 2: page 1 count mismatch");
        applyStimulus(1, 8'h80, 45'h2B0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 8'h81, 45'h2B1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 8'd5);
        checkOutput("s2_pv", page_valid, 2'b11);
        checkOutput("s2_n1", nentries_1_dout, 5);
        checkOutput("s2_err", count_err, 2'b10);
        applyStimulus(1, 8'h80, 45'h2C0, 0, 0, 0, 0, 0, 0);
        checkOutput("s2_refill_err", count_err, 2'b10);
        checkOutput("s2_refill_pv", page_valid, 2'b01);
        checkOutput("s2_refill_n1", nentries_1_dout, 0);

        // 3: page 0 reuse after VALID
        $display("[TB] step 3: page 0 reuse");
        applyStimulus(1, 8'h00, 45'h1B0, 0, 0, 0, 0, 0, 0);
        checkOutput("s3_n0_cleared", nentries_0_dout, 0);
        checkOutput("s3_pv", page_valid, 2'b00);
        applyStimulus(0, 0, 0, 0, 0, 1, 8'd1, 0, 0);
        checkOutput("s3_n0", nentries_0_dout, 1);
        checkOutput("s3_pv_valid", page_valid, 2'b01);
        checkOutput("s3_err", count_err, 2'b10);

        // 4: read-during-write to the same address
        $display("[TB] step 4: read during write");
        applyStimulus(1, 8'h05, 45'h123, 0, 0, 0, 0, 0, 0);
`ifdef FM_MEM_RDW_BYPASS_EN
        exp_rdw = 45'hABC;
`else
        exp_rdw = 45'h123;
`endif
        applyStimulus(1, 8'h05, 45'hABC, 1, 8'h05, 0, 0, 0, 0);
        checkOutput("s4_rdw", dout, exp_rdw);
        applyStimulus(0, 0, 0, 1, 8'h05, 0, 0, 0, 0);
        checkOutput("s4_rd_after", dout, 45'hABC);

        // 5: close page 0 (2 writes), then empty BX, then write+count same cycle
        $display("[TB] step 5: empty BX and same-cycle close");
        applyStimulus(0, 0, 0, 0, 0, 1, 8'd2, 0, 0);
        checkOutput("s5_n0_two", nentries_0_dout, 2);
        checkOutput("s5_err_two", count_err, 2'b10);
        applyStimulus(0, 0, 0, 0, 0, 1, 8'd0, 0, 0);
        checkOutput("s5_empty_n0", nentries_0_dout, 0);
        checkOutput("s5_empty_pv", page_valid, 2'b01);
        checkOutput("s5_empty_err", count_err, 2'b10);
        applyStimulus(1, 8'h00, 45'h1C0, 0, 0, 1, 8'd1, 0, 0);
        checkOutput("s5_same_n0", nentries_0_dout, 1);
        checkOutput("s5_same_pv", page_valid, 2'b01);
        checkOutput("s5_same_err", count_err, 2'b10);
        applyStimulus(0, 0, 0, 1, 8'h00, 0, 0, 0, 0);
        checkOutput("s5_same_rd", dout, 45'h1C0);

        // 6: async reset mid-fill, then refill counts from 1
        $display("[TB] step 6: reset mid-fill");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 8'd1);
        checkOutput("s6_pv_both", page_valid, 2'b11);
        checkOutput("s6_n1", nentries_1_dout, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 8'(8'h10 + i), 45'(45'h300 + i), 0, 0, 0, 0, 0, 0);
        end
        checkOutput("s6_pv_filling", page_valid, 2'b10);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("s6_rst_pv", page_valid, 0);
        checkOutput("s6_rst_err", count_err, 0);
        checkOutput("s6_rst_n1", nentries_1_dout, 0);
        checkOutput("s6_rst_dout", dout, 0);
        tick();
        reset = 1'b0;
        tick();
        applyStimulus(1, 8'h00, 45'h1D0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 8'h01, 45'h1D1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 8'd2, 0, 0);
        checkOutput("s6_refill_n0", nentries_0_dout, 2);
        checkOutput("s6_refill_err", count_err, 2'b00);
        checkOutput("s6_refill_pv", page_valid, 2'b01);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 8'd3);
        checkOutput("s6_p1_mismatch_err", count_err, 2'b10);

        $display("%0d/%0d checks passed", num_pass, num_checks);
        $finish;
    end

endmodule
